// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data access.
// Requests are latched at grant; a watchdog aborts transactions the memory never acks.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_valid,
    output logic [31:0] inst_rdata,
    input  logic        data_rd,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_mask,
    input  logic [31:0] data_wdata,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;

    localparam logic [7:0] WD_LIM = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  wd_q, wd_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        inst_valid_q, inst_valid_d;
    logic        data_valid_q, data_valid_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        bus_err_q, bus_err_d;

    logic data_pend;
    logic pick_data;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_mask_d   = mem_mask_q;
        mem_wdata_d  = mem_wdata_q;
        inst_valid_d = 1'b0;
        data_valid_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_err_d    = bus_err_q;
        data_pend    = data_rd | data_wr;
        // last_grant_q = 1 means data owned the previous grant
        pick_data    = data_pend &
                       (!inst_req || DATA_FIRST || !last_grant_q);

        unique case (state_q)
            IDLE: begin
                if (inst_req || data_pend) begin
                    last_grant_d = pick_data;
                    wd_d         = 8'd0;
                    mem_req_d    = 1'b1;
                    if (pick_data) begin
                        state_d     = DATA;
                        mem_addr_d  = data_addr;
                        mem_we_d    = data_wr;
                        mem_mask_d  = data_wr ? data_mask : 4'hF;
                        mem_wdata_d = data_wdata;
                    end else begin
                        state_d    = INST;
                        mem_addr_d = inst_addr;
                        mem_we_d   = 1'b0;
                        mem_mask_d = 4'hF;
                    end
                end
            end
            INST, DATA: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == INST) begin
                        inst_valid_d = 1'b1;
                        inst_rdata_d = mem_rdata;
                    end else begin
                        data_valid_d = 1'b1;
                        if (!mem_we_q) data_rdata_d = mem_rdata;
                    end
                end else if (wd_q == WD_LIM) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = RESP;
                    if (state_q == INST) begin
                        inst_valid_d = 1'b1;
                        inst_rdata_d = 32'h0;
                    end else begin
                        data_valid_d = 1'b1;
                        data_rdata_d = 32'h0;
                    end
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            wd_q         <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_mask_q   <= 4'h0;
            mem_wdata_q  <= 32'h0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_mask_q   <= mem_mask_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_valid_q <= inst_valid_d;
            data_valid_q <= data_valid_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_rdata = inst_rdata_q;
    assign data_valid = data_valid_q;
    assign data_rdata = data_rdata_q;
    assign bus_err    = bus_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_mask   = mem_mask_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed and random transactions against a
// cycle-count/latency model, plus a round-robin instance.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // instance A: data-first, short timeout
    logic        inst_req_a, inst_valid_a, data_rd_a, data_wr_a, data_valid_a;
    logic [31:0] inst_addr_a, inst_rdata_a, data_addr_a, data_wdata_a, data_rdata_a;
    logic [3:0]  data_mask_a, mem_mask_a;
    logic        bus_err_a, mem_req_a, mem_we_a, mem_ack_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

    // instance B: round-robin, always-ready memory
    logic        inst_req_b, inst_valid_b, data_rd_b, data_wr_b, data_valid_b;
    logic [31:0] inst_addr_b, inst_rdata_b, data_addr_b, data_wdata_b, data_rdata_b;
    logic [3:0]  data_mask_b, mem_mask_b;
    logic        bus_err_b, mem_req_b, mem_we_b, mem_ack_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_arbiter #(.TIMEOUT(TO), .DATA_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .inst_req(inst_req_a), .inst_addr(inst_addr_a),
        .inst_valid(inst_valid_a), .inst_rdata(inst_rdata_a),
        .data_rd(data_rd_a), .data_wr(data_wr_a), .data_addr(data_addr_a),
        .data_mask(data_mask_a), .data_wdata(data_wdata_a),
        .data_valid(data_valid_a), .data_rdata(data_rdata_a),
        .bus_err(bus_err_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_mask(mem_mask_a), .mem_wdata(mem_wdata_a),
        .mem_ack(mem_ack_a), .mem_rdata(mem_rdata_a)
    );

    mem_arbiter #(.TIMEOUT(16), .DATA_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .inst_req(inst_req_b), .inst_addr(inst_addr_b),
        .inst_valid(inst_valid_b), .inst_rdata(inst_rdata_b),
        .data_rd(data_rd_b), .data_wr(data_wr_b), .data_addr(data_addr_b),
        .data_mask(data_mask_b), .data_wdata(data_wdata_b),
        .data_valid(data_valid_b), .data_rdata(data_rdata_b),
        .bus_err(bus_err_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_mask(mem_mask_b), .mem_wdata(mem_wdata_b),
        .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b)
    );

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // memory A acks after wt_a wait cycles; stray_a injects an unsolicited ack
    int unsigned wt_a = 0;
    int unsigned cnt_a;
    logic        stray_a = 1'b0;
    assign mem_ack_a   = (mem_req_a && cnt_a == wt_a) || stray_a;
    assign mem_rdata_a = mem_ack_a ? rd_word(mem_addr_a) : 32'hDEAD_BEEF;
    always @(posedge clk or posedge reset) begin
        if (reset) cnt_a <= 0;
        else cnt_a <= (mem_req_a && !mem_ack_a) ? cnt_a + 1 : 0;
    end

    assign mem_ack_b   = mem_req_b;
    assign mem_rdata_b = mem_addr_b + 32'h1;

    logic        exp_err;
    logic [31:0] exp_ird, exp_drd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 load+store asserted together
    task automatic txn_a(input int kind, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wd,
                         input int unsigned wt);
        bit          wr = (kind >= 2);
        bit          isi = (kind == 0);
        bit          tmo = (wt >= TO);
        int          exp_hi = tmo ? TO : int'(wt) + 1;
        int          hi = 0;
        logic [3:0]  emask = wr ? mask : 4'hF;
        wt_a = wt;
        @(negedge clk);
        inst_req_a   = isi;
        inst_addr_a  = addr;
        data_rd_a    = (kind == 1 || kind == 3);
        data_wr_a    = wr;
        data_addr_a  = addr;
        data_mask_a  = mask;
        data_wdata_a = wd;
        @(negedge clk);
        while (mem_req_a && hi < 40) begin
            chk("hold_addr", mem_addr_a, addr);
            chk("hold_we", 32'(mem_we_a), 32'(wr));
            chk("hold_mask", 32'(mem_mask_a), 32'(emask));
            if (wr) chk("hold_wdata", mem_wdata_a, wd);
            chk("early_valid", 32'({inst_valid_a, data_valid_a}), 32'h0);
            inst_addr_a  = $urandom;
            data_addr_a  = $urandom;
            data_mask_a  = 4'($urandom);
            data_wdata_a = $urandom;
            hi++;
            @(negedge clk);
        end
        chk("req_cycles", 32'(hi), 32'(exp_hi));
        if (tmo) exp_err = 1'b1;
        if (isi) exp_ird = tmo ? 32'h0 : rd_word(addr);
        else if (tmo) exp_drd = 32'h0;
        else if (!wr) exp_drd = rd_word(addr);
        chk("inst_valid", 32'(inst_valid_a), 32'(isi));
        chk("data_valid", 32'(data_valid_a), 32'(!isi));
        chk("inst_rdata", inst_rdata_a, exp_ird);
        chk("data_rdata", data_rdata_a, exp_drd);
        chk("bus_err", 32'(bus_err_a), 32'(exp_err));
        inst_req_a = 1'b0;
        data_rd_a  = 1'b0;
        data_wr_a  = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'({inst_valid_a, data_valid_a}), 32'h0);
        chk("post_req", 32'(mem_req_a), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hung expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int vi, vd, g;
        logic prev;
        logic [31:0] ea;
        inst_req_a = 0; inst_addr_a = 0; data_rd_a = 0; data_wr_a = 0;
        data_addr_a = 0; data_mask_a = 0; data_wdata_a = 0;
        inst_req_b = 0; inst_addr_b = 0; data_rd_b = 0; data_wr_b = 0;
        data_addr_b = 0; data_mask_b = 0; data_wdata_b = 0;
        exp_err = 0; exp_ird = 0; exp_drd = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req_a), 32'h0);
        chk("rst_outs", 32'({mem_we_a, inst_valid_a, data_valid_a, bus_err_a,
                             mem_mask_a}), 32'h0);
        chk("rst_addr", mem_addr_a, 32'h0);
        chk("rst_rdata", inst_rdata_a | data_rdata_a, 32'h0);
        reset = 1'b0;

        txn_a(0, 32'h100, 4'h0, 32'h0, 0);
        chk("fetch_word", inst_rdata_a, 32'h0050_0093);
        txn_a(2, 32'h200, 4'b0011, 32'hAABB_CCDD, 3);
        txn_a(1, 32'h204, 4'h0, 32'h0, 1);
        txn_a(2, 32'h208, 4'b1000, 32'h1122_3344, 0);
        txn_a(3, 32'h20C, 4'b0110, 32'h5566_7788, 2);

        @(negedge clk);
        stray_a = 1'b1;
        repeat (2) @(negedge clk);
        stray_a = 1'b0;
        chk("stray_req", 32'(mem_req_a), 32'h0);
        chk("stray_valid", 32'({inst_valid_a, data_valid_a}), 32'h0);

        wt_a = 0;
        @(negedge clk);
        inst_req_a = 1; inst_addr_a = 32'h300;
        data_rd_a = 1; data_addr_a = 32'h400;
        vi = -1; vd = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) chk("cont_first", mem_addr_a, 32'h400);
            if (data_valid_a && vd < 0) begin
                vd = c; data_rd_a = 0;
                exp_drd = rd_word(32'h400);
                chk("cont_drd", data_rdata_a, exp_drd);
            end
            if (inst_valid_a && vi < 0) begin
                vi = c; inst_req_a = 0;
                exp_ird = rd_word(32'h300);
                chk("cont_ird", inst_rdata_a, exp_ird);
            end
        end
        inst_req_a = 0; data_rd_a = 0;
        chk("cont_dcycle", 32'(vd), 32'd2);
        chk("cont_icycle", 32'(vi), 32'd5);

        for (int i = 0; i < 25; i++)
            txn_a($urandom_range(0, 3), $urandom & ~32'h3, 4'($urandom),
                  $urandom, $urandom_range(0, TO - 1));

        txn_a(0, 32'h600, 4'h0, 32'h0, TO);
        chk("err_sticky", 32'(bus_err_a), 32'h1);

        for (int i = 0; i < 20; i++)
            txn_a($urandom_range(0, 3), $urandom & ~32'h3, 4'($urandom),
                  $urandom, $urandom_range(0, TO + 2));

        wt_a = 50;
        @(negedge clk);
        data_rd_a = 1; data_addr_a = 32'h700;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", 32'(mem_req_a), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req_a), 32'h0);
        chk("arst_flags", 32'({inst_valid_a, data_valid_a, bus_err_a}), 32'h0);
        chk("arst_rdata", inst_rdata_a | data_rdata_a, 32'h0);
        data_rd_a = 0;
        @(negedge clk);
        reset = 1'b0;
        exp_err = 0; exp_ird = 0; exp_drd = 0;
        txn_a(0, 32'h800, 4'h0, 32'h0, 1);

        @(negedge clk);
        inst_req_b = 1; inst_addr_b = 32'h1000;
        data_addr_b = 32'h2000;
        prev = 1'b0; g = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) data_rd_b = 1;
            if (mem_req_b && !prev && g < 6) begin
                ea = (g % 2 == 0) ? 32'h1000 : 32'h2000;
                chk("rr_grant", mem_addr_b, ea);
                g++;
            end
            if (inst_valid_b) chk("rr_ird", inst_rdata_b, 32'h1001);
            if (data_valid_b) chk("rr_drd", data_rdata_b, 32'h2001);
            prev = mem_req_b;
        end
        inst_req_b = 0; data_rd_b = 0;
        chk("rr_count", 32'(g), 32'd6);
        chk("rr_err", 32'(bus_err_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
